// File: rtl/pdm_decimator.sv
// PDM-to-PCM decimator: counts ones over a DECIM-sample window and emits one
// signed sample (2*ones - DECIM) per window through a valid/ready handshake.
module pdm_decimator #(
    parameter int unsigned DECIM = 64,
    parameter int unsigned CW    = $clog2(DECIM + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        sample_en,
    input  logic        pdm_in,
    output logic [CW:0] pcm_data,
    output logic        pcm_valid,
    input  logic        pcm_ready,
    output logic        overrun,
    input  logic        clear_overrun
);

    localparam int unsigned SW = $clog2(DECIM);
    localparam int unsigned PW = CW + 1;

    logic [CW-1:0] ones_cnt;
    logic [SW-1:0] samp_cnt;

    logic          last_c;
    logic          win_done_c;
    logic          xfer_c;
    logic          ovr_set_c;
    logic [CW-1:0] total_c;
    logic [PW-1:0] pcm_next_c;

    // Window-complete detection, handshake events and the new sample value
    always_comb begin
        last_c     = (samp_cnt == SW'(DECIM - 1));
        win_done_c = enable && sample_en && last_c;
        xfer_c     = pcm_valid && pcm_ready;
        ovr_set_c  = win_done_c && pcm_valid && !pcm_ready;
        // final bit of the window is folded in before scaling
        total_c    = ones_cnt + CW'(pdm_in);
        pcm_next_c = {total_c, 1'b0} - PW'(DECIM);
    end

    // Sample and ones counters; disabled block restarts from an empty window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp_cnt <= '0;
            ones_cnt <= '0;
        end else if (!enable) begin
            samp_cnt <= '0;
            ones_cnt <= '0;
        end else if (sample_en) begin
            if (last_c) begin
                samp_cnt <= '0;
                ones_cnt <= '0;
            end else begin
                samp_cnt <= samp_cnt + SW'(1);
                ones_cnt <= total_c;
            end
        end
    end

    // Output register: a completed window always loads, a transfer drops valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcm_data  <= '0;
            pcm_valid <= 1'b0;
        end else if (win_done_c) begin
            pcm_data  <= pcm_next_c;
            pcm_valid <= 1'b1;
        end else if (xfer_c) begin
            pcm_valid <= 1'b0;
        end
    end

    // Sticky overwrite flag; a new overwrite beats a same-edge clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (ovr_set_c) begin
            overrun <= 1'b1;
        end else if (clear_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pdm_decimator.sv
// Scoreboard bench for pdm_decimator: stimulus pushes expected samples,
// a negedge monitor pops and compares on every handshake transfer.
module tb_pdm_decimator;

    localparam int unsigned DECIM = 64;
    localparam int unsigned CW    = $clog2(DECIM + 1);

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        sample_en;
    logic        pdm_in;
    logic [CW:0] pcm_data;
    logic        pcm_valid;
    logic        pcm_ready;
    logic        overrun;
    logic        clear_overrun;

    int total = 0;
    int bad   = 0;

    int   exp_q[$];
    int   m_samp, m_ones, m_data;
    logic m_valid, m_ovr;
    logic rdy_rand = 1'b0;

    pdm_decimator #(.DECIM(DECIM)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sample_en    (sample_en),
        .pdm_in       (pdm_in),
        .pcm_data     (pcm_data),
        .pcm_valid    (pcm_valid),
        .pcm_ready    (pcm_ready),
        .overrun      (overrun),
        .clear_overrun(clear_overrun)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every transfer must match the oldest outstanding expected sample
    always @(negedge clk) begin
        if (!reset && pcm_valid && pcm_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL xfer_unexpected: got=%0d want=none at t=%0t",
                         $signed(pcm_data), $time);
            end else begin
                chk("xfer_data", $signed(pcm_data), exp_q.pop_front());
            end
        end
    end

    function automatic void model_reset();
        m_samp  = 0;
        m_ones  = 0;
        m_data  = 0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        exp_q.delete();
    endfunction

    // One clock: drive inputs, advance the model, then compare visible state
    task automatic tick(input logic se, input logic b);
        logic win, ovr_set;
        int   tot;
        if (rdy_rand) pcm_ready = 1'($urandom_range(0, 1));
        sample_en = se;
        pdm_in    = b;
        win     = enable && se && (m_samp == DECIM - 1);
        ovr_set = win && m_valid && !pcm_ready;
        if (win) begin
            tot = m_ones + int'(b);
            if (ovr_set && exp_q.size() > 0) void'(exp_q.pop_back());
            exp_q.push_back(2 * tot - DECIM);
            m_data  = 2 * tot - DECIM;
            m_valid = 1'b1;
        end else if (m_valid && pcm_ready) begin
            m_valid = 1'b0;
        end
        if (ovr_set) m_ovr = 1'b1;
        else if (clear_overrun) m_ovr = 1'b0;
        if (!enable) begin
            m_samp = 0;
            m_ones = 0;
        end else if (se) begin
            if (m_samp == DECIM - 1) begin
                m_samp = 0;
                m_ones = 0;
            end else begin
                m_samp = m_samp + 1;
                m_ones = m_ones + int'(b);
            end
        end
        @(posedge clk);
        #1;
        clear_overrun = 1'b0;
        sample_en     = 1'b0;
        chk("valid", int'(pcm_valid), int'(m_valid));
        chk("overrun", int'(overrun), int'(m_ovr));
        if (m_valid) chk("data", $signed(pcm_data), m_data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    // n pulses with bits pat[0..n-1], gap clocks between pulses
    task automatic run(input int n, input logic [63:0] pat, input int gap);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, pat[i]);
            if (i != n - 1) idle(gap - 1);
        end
    endtask

    initial begin
        reset         = 1'b1;
        enable        = 1'b1;
        sample_en     = 1'b0;
        pdm_in        = 1'b0;
        pcm_ready     = 1'b0;
        clear_overrun = 1'b0;
        model_reset();
        #12;
        chk("rst_data", int'(pcm_data), 0);
        chk("rst_valid", int'(pcm_valid), 0);
        chk("rst_overrun", int'(overrun), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // All ones, slow mic tick, two consecutive windows
        pcm_ready = 1'b1;
        for (int w = 0; w < 2; w++) begin
            run(64, {64{1'b1}}, 42);
            chk("ones_valid", int'(pcm_valid), 1);
            chk("ones_data", $signed(pcm_data), 64);
            idle(41);
        end

        // Idle patterns and the final-bit inclusion
        run(64, 64'hAAAA_AAAA_AAAA_AAAA, 2);
        chk("alt_data", $signed(pcm_data), 0);
        idle(3);
        run(64, 64'h0, 2);
        chk("zero_data", $signed(pcm_data), -64);
        idle(3);
        run(64, 64'h8000_0000_0000_0000, 2);
        chk("lastbit_data", $signed(pcm_data), -62);
        idle(3);

        // Backpressure through two windows, then overwrite and clear
        pcm_ready = 1'b0;
        run(64, 64'h0000_00FF_FFFF_FFFF, 2);
        chk("bp1_data", $signed(pcm_data), 16);
        chk("bp1_overrun", int'(overrun), 0);
        run(30, 64'h3FF, 2);
        idle(1);
        chk("bp_hold_data", $signed(pcm_data), 16);
        run(34, 64'h0, 2);
        chk("bp2_data", $signed(pcm_data), -44);
        chk("bp2_overrun", int'(overrun), 1);
        idle(2);
        clear_overrun = 1'b1;
        tick(1'b0, 1'b0);
        chk("clr_overrun", int'(overrun), 0);
        pcm_ready = 1'b1;
        idle(3);

        // Ready arrives on the very edge the next window completes
        pcm_ready = 1'b0;
        run(64, {64{1'b1}}, 2);
        idle(1);
        run(63, 64'h0, 2);
        idle(1);
        pcm_ready = 1'b1;
        tick(1'b1, 1'b0);
        pcm_ready = 1'b0;
        chk("same_valid", int'(pcm_valid), 1);
        chk("same_data", $signed(pcm_data), -64);
        chk("same_overrun", int'(overrun), 0);
        pcm_ready = 1'b1;
        idle(3);

        // Enable drop mid-window discards the partial window
        run(30, 64'h0, 2);
        idle(2);
        enable = 1'b0;
        run(5, {64{1'b1}}, 2);
        idle(2);
        enable = 1'b1;
        run(63, {64{1'b1}}, 2);
        idle(2);
        chk("en_partial_valid", int'(pcm_valid), 0);
        tick(1'b1, 1'b1);
        chk("en_full_data", $signed(pcm_data), 64);
        idle(3);

        // Asynchronous reset mid-window with a pending sample and overrun
        pcm_ready = 1'b0;
        run(64, {64{1'b1}}, 2);
        run(64, 64'h0, 2);
        chk("pre_rst_overrun", int'(overrun), 1);
        run(20, {64{1'b1}}, 2);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_data", int'(pcm_data), 0);
        chk("arst_valid", int'(pcm_valid), 0);
        chk("arst_overrun", int'(overrun), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        pcm_ready = 1'b1;
        run(63, {64{1'b1}}, 2);
        idle(2);
        chk("post_rst_valid", int'(pcm_valid), 0);
        tick(1'b1, 1'b1);
        chk("post_rst_data", $signed(pcm_data), 64);
        idle(3);

        // Random bitstream, random spacing (incl. back-to-back), random ready
        rdy_rand = 1'b1;
        for (int w = 0; w < 100; w++) begin
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(0, 15) == 0) clear_overrun = 1'b1;
                tick(1'b1, 1'($urandom_range(0, 1)));
                idle(int'($urandom_range(0, 2)));
            end
        end
        rdy_rand  = 1'b0;
        pcm_ready = 1'b1;
        idle(4);
        chk("drain_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pdm_decimator.md
Name: pdm_decimator

Overview:
- Downstream stage of the PDM microphone capture block.
- Consumes the 1-bit PDM stream, one bit per sample-enable pulse at ~2.4 MHz, taken from the mic clock tick.
- Counts ones over a fixed window of DECIM samples and emits one signed PCM sample per window through a valid/ready handshake.
- Feeds the audio buffer / PWM playback path in the system clock domain.

Parameters:
- DECIM, 64, samples per output window; integer >= 2.
- CW, $clog2(DECIM+1), width of the ones counter, i.e. the unsigned count range 0..DECIM.

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-high reset
- enable  in  1  block enable; low clears the window and suppresses new output
- sample_en  in  1  one-clk pulse marking a valid PDM bit (mic clock tick)
- pdm_in  in  1  registered PDM bit from the capture stage
- pcm_data  out  CW+1  signed sample = 2*ones - DECIM, range -DECIM..+DECIM
- pcm_valid  out  1  output sample available
- pcm_ready  in  1  consumer accepts pcm_data when pcm_valid && pcm_ready
- overrun  out  1  sticky flag: an unconsumed sample was overwritten
- clear_overrun  in  1  synchronous clear of overrun

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: all outputs and internal registers are 0, including pcm_data, pcm_valid, overrun, ones_cnt and samp_cnt.
- Internal state:
  - ones_cnt [CW-1:0]
  - samp_cnt [$clog2(DECIM)-1:0]
- Accumulation phase: on a clk edge with enable=1 and sample_en=1 and samp_cnt < DECIM-1:
  - samp_cnt <= samp_cnt+1
  - ones_cnt <= ones_cnt + pdm_in
- Window-complete phase: on a clk edge with enable=1, sample_en=1 and samp_cnt == DECIM-1:
  - total = ones_cnt + pdm_in, so the final bit is included.
  - pcm_data <= 2*total - DECIM, computed in CW+1 signed bits. No overflow is possible.
  - pcm_valid <= 1.
  - samp_cnt and ones_cnt <= 0.
- Latency: pcm_valid rises on the clk edge that processes the DECIM-th sample_en, i.e. visible the cycle after that pulse.
- Clock cycles without sample_en leave the counters unchanged.
- enable=0:
  - samp_cnt and ones_cnt are held at 0, and sample_en is ignored.
  - An already-valid output sample stays valid until consumed.
  - Re-enabling starts a fresh window.
- Handshake:
  - When pcm_valid=1, pcm_data is stable until the transfer edge (pcm_valid && pcm_ready).
  - At the transfer edge, pcm_valid <= 0 unless a window completes on the same edge.
- Simultaneous transfer and window complete: the new sample loads and pcm_valid stays 1. overrun is not set.
- Overwrite: a window completes while pcm_valid=1 and pcm_ready=0.
  - The new sample overwrites pcm_data and pcm_valid stays 1.
  - overrun <= 1.
- overrun:
  - Sticky; cleared only by clear_overrun or reset.
  - If clear_overrun and a new overwrite event occur on the same edge, set wins and overrun stays 1.
- pcm_ready while pcm_valid=0 has no effect.
- Reset mid-window: the partial window is discarded. The first post-reset window needs a full DECIM sample_en pulses.
- sample_en pulses are at least 2 clk apart. Back-to-back pulses are still handled correctly, one bit per pulse.

Test Plan:
- All-ones: DECIM=64, pdm_in=1, 64 sample_en pulses spaced 42 clk, pcm_ready=1 -> pcm_valid pulses one cycle after the 64th pulse with pcm_data=+64. Repeats every 64 pulses.
- Idle pattern: alternating 1/0 and all-zeros windows -> pcm_data=0 and pcm_data=-64 respectively. The last bit of each window is counted (pattern with only the final bit 1 -> -62).
- Backpressure: pcm_ready=0 through two windows of 40 ones then 10 ones:
  - pcm_data holds +16 until the second window completes, then changes to -44.
  - overrun=1 from that point.
  - clear_overrun pulse -> overrun=0.
- Same-edge handshake: assert pcm_ready exactly on the edge the next window completes -> pcm_valid stays 1, new data loaded, overrun stays 0.
- Enable and reset mid-window:
  - Drop enable after 30 sample_en, re-enable -> the next output needs a full 64 fresh pulses.
  - Assert reset asynchronously mid-window -> all outputs go to 0 immediately, with no spurious pcm_valid.
- Random PDM bitstream over 100 windows with random pcm_ready -> every transferred sample matches a reference model of 2*popcount-64. overrun sets only on genuine overwrites.
